// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the way0/way1 data-RAM port arbiter.
package mem_arb_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 64;
    localparam int ARB_MASK_W = 4;

    localparam logic [2:0] WSTATE_DONE = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic                  we;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
        logic [ARB_MASK_W-1:0] wmask;
        logic [1:0]            pid;
    } mem_req_t;

    // pid_a is older when pid_b lies one or two steps after it on the 2-bit ring
    function automatic logic is_older(input logic [1:0] pid_a, input logic [1:0] pid_b);
        logic [1:0] diff;
        diff = pid_b - pid_a;
        return (diff == 2'd1) || (diff == 2'd2);
    endfunction

endpackage

// File: rtl/mem_arb_hold_entry.sv
// One-entry request holding register for a single way.
module mem_arb_hold_entry
    import mem_arb_pkg::*;
(
    input  logic     clk,
    input  logic     reset_n,
    input  logic     load_i,
    input  mem_req_t req_i,
    input  logic     clear_i,
    input  logic     flush_i,
    input  logic     granted_i,
    output logic     valid_o,
    output mem_req_t req_o
);

    logic     valid_q, valid_d;
    mem_req_t req_q, req_d;

    // A granted entry survives a flush so the bus transaction can finish
    always_comb begin
        valid_d = valid_q;
        req_d   = req_q;
        if (clear_i || (flush_i && !granted_i)) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            req_d   = req_i;
        end else begin
            valid_d = valid_q;
        end
    end

    // Entry storage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            req_q   <= '0;
        end else begin
            valid_q <= valid_d;
            req_q   <= req_d;
        end
    end

    assign valid_o = valid_q;
    assign req_o   = req_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single data-RAM port between the way0 and way1 memory stages,
// oldest pID first, with back-to-back chaining of the next held request.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W,
    parameter int MASK_W = ARB_MASK_W
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                flush_i,
    input  logic [1:0]          req_valid_i,
    output logic [1:0]          req_ready_o,
    input  logic [1:0]          req_we_i,
    input  logic [2*ADDR_W-1:0] req_addr_i,
    input  logic [2*DATA_W-1:0] req_wdata_i,
    input  logic [2*MASK_W-1:0] req_wmask_i,
    input  logic [3:0]          req_pid_i,
    output logic [1:0]          rsp_valid_o,
    output logic [2*DATA_W-1:0] rsp_rdata_o,
    output logic [ADDR_W-1:0]   mem_raddr_o,
    output logic [ADDR_W-1:0]   mem_waddr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [MASK_W-1:0]   mem_wmask_o,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    input  logic                mem_data_ok_i,
    input  logic [2:0]          mem_wstate_i,
    output logic                busy_o
);

    arb_state_e          state_q, state_d;
    logic                grant_q, grant_d;
    logic                flushed_q, flushed_d;
    logic [1:0]          rsp_valid_q, rsp_valid_d;
    logic [2*DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    mem_req_t   req_in_s   [2];
    mem_req_t   hold_req_s [2];
    mem_req_t   cur_s;
    logic [1:0] hold_valid_s, accept_s, zero_addr_s, load_s, clear_s, granted_s;
    logic       busy_s, done_s, pick_s, other_s;

    assign busy_s      = (state_q != IDLE);
    assign other_s     = ~grant_q;
    assign cur_s       = hold_req_s[grant_q];
    assign req_ready_o = ~hold_valid_s & {2{~flush_i}};

    for (genvar w = 0; w < 2; w++) begin : g_way
        assign req_in_s[w]    = {req_we_i[w], req_addr_i[w*ADDR_W +: ADDR_W],
                                 req_wdata_i[w*DATA_W +: DATA_W],
                                 req_wmask_i[w*MASK_W +: MASK_W], req_pid_i[w*2 +: 2]};
        assign accept_s[w]    = req_valid_i[w] & req_ready_o[w];
        // Address 0 means an idle bus, so such requests are answered without holding
        assign zero_addr_s[w] = (req_addr_i[w*ADDR_W +: ADDR_W] == '0);
        assign load_s[w]      = accept_s[w] & ~zero_addr_s[w];
        assign granted_s[w]   = busy_s & (grant_q == 1'(w));
        assign clear_s[w]     = granted_s[w] & done_s;

        mem_arb_hold_entry u_hold (
            .clk       (clk),
            .reset_n   (reset_n),
            .load_i    (load_s[w]),
            .req_i     (req_in_s[w]),
            .clear_i   (clear_s[w]),
            .flush_i   (flush_i),
            .granted_i (granted_s[w]),
            .valid_o   (hold_valid_s[w]),
            .req_o     (hold_req_s[w])
        );
    end

    // Way1 wins only when strictly older; a tie or the ambiguous half-ring distance favours way0
    assign pick_s = hold_valid_s[1] &
                    (~hold_valid_s[0] |
                     (is_older(hold_req_s[1].pid, hold_req_s[0].pid) &
                      ~is_older(hold_req_s[0].pid, hold_req_s[1].pid)));

    // Completion of the in-flight transaction
    always_comb begin
        done_s = 1'b0;
        case (state_q)
            READ:    done_s = mem_data_ok_i;
            WRITE:   done_s = (mem_wstate_i == WSTATE_DONE);
            default: done_s = 1'b0;
        endcase
    end

    // FSM state, grant and flush-seen registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            grant_q   <= 1'b0;
            flushed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            flushed_q <= flushed_d;
        end
    end

    // Next-state: grant from IDLE, or chain straight to the other hold on completion
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        flushed_d = flushed_q;
        case (state_q)
            IDLE: begin
                flushed_d = 1'b0;
                if ((|hold_valid_s) && !flush_i) begin
                    grant_d = pick_s;
                    state_d = hold_req_s[pick_s].we ? WRITE : READ;
                end else begin
                    state_d = IDLE;
                end
            end
            READ, WRITE: begin
                if (done_s) begin
                    flushed_d = 1'b0;
                    if (hold_valid_s[other_s] && !flush_i) begin
                        grant_d = other_s;
                        state_d = hold_req_s[other_s].we ? WRITE : READ;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    flushed_d = flushed_q | flush_i;
                end
            end
            default: begin
                state_d   = IDLE;
                flushed_d = 1'b0;
            end
        endcase
    end

    // Bus outputs: driven only by the granted hold, zero otherwise
    always_comb begin
        mem_raddr_o = '0;
        mem_waddr_o = '0;
        mem_wdata_o = '0;
        mem_wmask_o = '0;
        case (state_q)
            READ: mem_raddr_o = cur_s.addr;
            WRITE: begin
                mem_waddr_o = cur_s.addr;
                mem_wdata_o = cur_s.wdata;
                mem_wmask_o = cur_s.wmask;
            end
            default: mem_raddr_o = '0;
        endcase
    end

    assign busy_o = busy_s;

    // Response pulses; data persists between pulses
    always_comb begin
        rsp_valid_d = 2'b00;
        rsp_rdata_d = rsp_rdata_q;
        for (int w = 0; w < 2; w++) begin
            if (accept_s[w] && zero_addr_s[w]) begin
                rsp_valid_d[w]                  = 1'b1;
                rsp_rdata_d[w*DATA_W +: DATA_W] = '0;
            end else begin
                rsp_valid_d[w] = 1'b0;
            end
        end
        if (done_s && !flush_i && !flushed_q) begin
            rsp_valid_d[grant_q]                  = 1'b1;
            rsp_rdata_d[grant_q*DATA_W +: DATA_W] = (state_q == READ) ? mem_rdata_i : '0;
        end else begin
            rsp_rdata_d = rsp_rdata_d;
        end
    end

    // Response registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed sequences, a priority
// table and randomized traffic against a behavioural model.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int MASK_W = 4;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                flush_i;
    logic [1:0]          req_valid_i;
    logic [1:0]          req_ready_o;
    logic [1:0]          req_we_i;
    logic [2*ADDR_W-1:0] req_addr_i;
    logic [2*DATA_W-1:0] req_wdata_i;
    logic [2*MASK_W-1:0] req_wmask_i;
    logic [3:0]          req_pid_i;
    logic [1:0]          rsp_valid_o;
    logic [2*DATA_W-1:0] rsp_rdata_o;
    logic [ADDR_W-1:0]   mem_raddr_o;
    logic [ADDR_W-1:0]   mem_waddr_o;
    logic [DATA_W-1:0]   mem_wdata_o;
    logic [MASK_W-1:0]   mem_wmask_o;
    logic [DATA_W-1:0]   mem_rdata_i;
    logic                mem_data_ok_i;
    logic [2:0]          mem_wstate_i;
    logic                busy_o;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .flush_i       (flush_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_we_i      (req_we_i),
        .req_addr_i    (req_addr_i),
        .req_wdata_i   (req_wdata_i),
        .req_wmask_i   (req_wmask_i),
        .req_pid_i     (req_pid_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_rdata_o   (rsp_rdata_o),
        .mem_raddr_o   (mem_raddr_o),
        .mem_waddr_o   (mem_waddr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_wmask_o   (mem_wmask_o),
        .mem_rdata_i   (mem_rdata_i),
        .mem_data_ok_i (mem_data_ok_i),
        .mem_wstate_i  (mem_wstate_i),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [1:0] pid0;
        logic [1:0] pid1;
        int         first;
    } prio_vec_t;

    prio_vec_t vecs [9];

    // behavioural model state
    logic        mh_v     [2];
    logic        mh_we    [2];
    logic [31:0] mh_addr  [2];
    logic [63:0] mh_wdata [2];
    logic [3:0]  mh_wmask [2];
    logic [1:0]  mh_pid   [2];
    logic [63:0] m_rsp_d  [2];
    logic [1:0]  m_rsp_v, nxt_rsp, e_ready;
    int          act, nact;
    logic        mflushed, done;
    logic [31:0] e_raddr, e_waddr;
    logic [63:0] e_wdata;
    logic [3:0]  e_wmask;

    task automatic check(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
        n_checks++;
        if (act_v !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act_v, exp_v, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid_i   = 2'b00;
        flush_i       = 1'b0;
        mem_data_ok_i = 1'b0;
        mem_wstate_i  = 3'b000;
    endtask

    task automatic set_req(input int w, input logic we, input logic [31:0] addr,
                           input logic [63:0] wdata, input logic [3:0] wmask, input logic [1:0] pid);
        req_valid_i[w]                  = 1'b1;
        req_we_i[w]                     = we;
        req_addr_i[w*ADDR_W +: ADDR_W]  = addr;
        req_wdata_i[w*DATA_W +: DATA_W] = wdata;
        req_wmask_i[w*MASK_W +: MASK_W] = wmask;
        req_pid_i[w*2 +: 2]             = pid;
    endtask

    // way1 goes first only when it is strictly the older of the two
    function automatic int model_pick(input logic [1:0] p0, input logic [1:0] p1);
        int d;
        d = (int'(p0) - int'(p1) + 4) % 4;
        return (d == 1) ? 1 : 0;
    endfunction

    initial begin
        vecs[0] = '{2'd0, 2'd0, 0};
        vecs[1] = '{2'd0, 2'd1, 0};
        vecs[2] = '{2'd1, 2'd0, 1};
        vecs[3] = '{2'd3, 2'd0, 0};
        vecs[4] = '{2'd0, 2'd3, 1};
        vecs[5] = '{2'd0, 2'd2, 0};
        vecs[6] = '{2'd2, 2'd0, 0};
        vecs[7] = '{2'd2, 2'd3, 0};
        vecs[8] = '{2'd3, 2'd2, 1};

        reset_n     = 1'b0;
        req_we_i    = 2'b00;
        req_addr_i  = '0;
        req_wdata_i = '0;
        req_wmask_i = '0;
        req_pid_i   = '0;
        mem_rdata_i = '0;
        idle_inputs();
        #1;
        check("reset_ready", 64'(req_ready_o), 64'h3);
        check("reset_busy", 64'(busy_o), 64'h0);
        check("reset_rsp", 64'(rsp_valid_o), 64'h0);
        check("reset_bus", 64'(mem_raddr_o | mem_waddr_o), 64'h0);
        tick();
        tick();
        reset_n = 1'b1;

        // single way0 read, data_ok three cycles after the bus is driven
        tick(); set_req(0, 1'b0, 32'h8000_0100, 64'h0, 4'h0, 2'd0); #1;
        check("t1_ready_c", 64'(req_ready_o[0]), 64'h1);
        tick(); idle_inputs(); #1;
        check("t1_ready_c1", 64'(req_ready_o[0]), 64'h0);
        check("t1_raddr_c1", 64'(mem_raddr_o), 64'h0);
        check("t1_busy_c1", 64'(busy_o), 64'h0);
        for (int k = 0; k < 3; k++) begin
            tick(); #1;
            check("t1_raddr", 64'(mem_raddr_o), 64'h8000_0100);
            check("t1_ready_low", 64'(req_ready_o[0]), 64'h0);
            check("t1_busy", 64'(busy_o), 64'h1);
        end
        tick(); mem_data_ok_i = 1'b1; mem_rdata_i = 64'hDEAD_BEEF_CAFE_F00D; #1;
        check("t1_raddr_d", 64'(mem_raddr_o), 64'h8000_0100);
        check("t1_rsp_d", 64'(rsp_valid_o), 64'h0);
        check("t1_ready_d", 64'(req_ready_o[0]), 64'h0);
        tick(); mem_data_ok_i = 1'b0; #1;
        check("t1_rsp_d1", 64'(rsp_valid_o), 64'h1);
        check("t1_rdata", rsp_rdata_o[63:0], 64'hDEAD_BEEF_CAFE_F00D);
        check("t1_raddr_d1", 64'(mem_raddr_o), 64'h0);
        check("t1_ready_d1", 64'(req_ready_o[0]), 64'h1);
        tick(); #1;
        check("t1_rsp_once", 64'(rsp_valid_o), 64'h0);

        // priority table: both ways request the same cycle
        for (int i = 0; i < 9; i++) begin
            tick();
            set_req(0, 1'b0, 32'h100, 64'h0, 4'h0, vecs[i].pid0);
            set_req(1, 1'b0, 32'h200, 64'h0, 4'h0, vecs[i].pid1);
            tick(); idle_inputs();
            tick(); mem_data_ok_i = 1'b1; mem_rdata_i = 64'(i); #1;
            check("prio_first", 64'(mem_raddr_o), (vecs[i].first == 0) ? 64'h100 : 64'h200);
            tick(); mem_data_ok_i = 1'b1; mem_rdata_i = 64'(i + 100); #1;
            check("prio_chain", 64'(mem_raddr_o), (vecs[i].first == 0) ? 64'h200 : 64'h100);
            check("prio_rsp1", 64'(rsp_valid_o), (vecs[i].first == 0) ? 64'h1 : 64'h2);
            tick(); idle_inputs(); #1;
            check("prio_rsp2", 64'(rsp_valid_o), (vecs[i].first == 0) ? 64'h2 : 64'h1);
            check("prio_idle", 64'(mem_raddr_o), 64'h0);
        end

        // way0 write pID 3 vs way1 read pID 0: wrap makes way0 older
        tick();
        set_req(0, 1'b1, 32'h8000_0040, 64'h1122_3344_5566_7788, 4'b1010, 2'd3);
        set_req(1, 1'b0, 32'h8000_0080, 64'h0, 4'h0, 2'd0);
        tick(); idle_inputs();
        tick(); mem_wstate_i = 3'b111; #1;
        check("t2_waddr", 64'(mem_waddr_o), 64'h8000_0040);
        check("t2_wdata", mem_wdata_o, 64'h1122_3344_5566_7788);
        check("t2_wmask", 64'(mem_wmask_o), 64'hA);
        check("t2_raddr0", 64'(mem_raddr_o), 64'h0);
        tick(); mem_wstate_i = 3'b000; #1;
        check("t2_chain_raddr", 64'(mem_raddr_o), 64'h8000_0080);
        check("t2_waddr_clr", 64'(mem_waddr_o), 64'h0);
        check("t2_busy", 64'(busy_o), 64'h1);
        check("t2_rsp0", 64'(rsp_valid_o), 64'h1);
        check("t2_wr_rdata", rsp_rdata_o[63:0], 64'h0);
        tick(); mem_data_ok_i = 1'b1; mem_rdata_i = 64'h0123_4567_89AB_CDEF; #1;
        tick(); idle_inputs(); #1;
        check("t2_rsp1", 64'(rsp_valid_o), 64'h2);
        check("t2_rdata1", rsp_rdata_o[127:64], 64'h0123_4567_89AB_CDEF);

        // write stalls on 3'b110 for five cycles
        tick(); set_req(1, 1'b1, 32'h9000_0000, 64'hCAFE, 4'hF, 2'd1);
        tick(); idle_inputs();
        for (int k = 0; k < 5; k++) begin
            tick(); mem_wstate_i = 3'b110; #1;
            check("t3_waddr_stable", 64'(mem_waddr_o), 64'h9000_0000);
            check("t3_no_rsp", 64'(rsp_valid_o), 64'h0);
            check("t3_busy", 64'(busy_o), 64'h1);
        end
        tick(); mem_wstate_i = 3'b111; #1;
        check("t3_waddr_done", 64'(mem_waddr_o), 64'h9000_0000);
        tick(); mem_wstate_i = 3'b000; #1;
        check("t3_rsp", 64'(rsp_valid_o), 64'h2);
        check("t3_waddr_clr", 64'(mem_waddr_o), 64'h0);
        tick(); #1;
        check("t3_rsp_once", 64'(rsp_valid_o), 64'h0);

        // address-0 request on way1 completes without touching the bus
        tick(); set_req(1, 1'b0, 32'h0, 64'h0, 4'h0, 2'd2); #1;
        check("t4_bus_c", 64'(mem_raddr_o | mem_waddr_o), 64'h0);
        tick(); idle_inputs(); #1;
        check("t4_rsp", 64'(rsp_valid_o), 64'h2);
        check("t4_rdata", rsp_rdata_o[127:64], 64'h0);
        check("t4_bus", 64'(mem_raddr_o | mem_waddr_o) | 64'(mem_wmask_o) | mem_wdata_o, 64'h0);
        check("t4_busy", 64'(busy_o), 64'h0);
        tick(); #1;
        check("t4_rsp_once", 64'(rsp_valid_o), 64'h0);
        check("t4_busy2", 64'(busy_o), 64'h0);

        // flush during an in-flight way0 read with way1 held
        tick(); set_req(0, 1'b0, 32'h8000_0200, 64'h0, 4'h0, 2'd0);
        tick(); idle_inputs();
        tick(); set_req(1, 1'b0, 32'h8000_0300, 64'h0, 4'h0, 2'd1); #1;
        check("t5_ready1", 64'(req_ready_o[1]), 64'h1);
        tick(); idle_inputs(); #1;
        check("t5_held1", 64'(req_ready_o[1]), 64'h0);
        tick(); flush_i = 1'b1; #1;
        check("t5_ready_flush", 64'(req_ready_o), 64'h0);
        tick(); flush_i = 1'b0; #1;
        check("t5_dropped1", 64'(req_ready_o), 64'h2);
        check("t5_inflight", 64'(mem_raddr_o), 64'h8000_0200);
        tick(); mem_data_ok_i = 1'b1; mem_rdata_i = 64'h5555; #1;
        tick(); idle_inputs(); #1;
        check("t5_no_rsp", 64'(rsp_valid_o), 64'h0);
        check("t5_idle", 64'(busy_o), 64'h0);
        check("t5_ready", 64'(req_ready_o), 64'h3);
        tick(); #1;
        check("t5_no_rsp2", 64'(rsp_valid_o), 64'h0);
        check("t5_bus_idle", 64'(mem_raddr_o), 64'h0);

        // asynchronous reset in the middle of a write
        tick(); set_req(0, 1'b1, 32'hA000_0000, 64'hFFFF_0000_FFFF_0000, 4'hF, 2'd0);
        tick(); idle_inputs();
        tick(); #1;
        check("t6_waddr", 64'(mem_waddr_o), 64'hA000_0000);
        #2; reset_n = 1'b0; #1;
        check("t6_waddr_rst", 64'(mem_waddr_o), 64'h0);
        check("t6_wdata_rst", mem_wdata_o, 64'h0);
        check("t6_busy_rst", 64'(busy_o), 64'h0);
        tick(); tick(); reset_n = 1'b1;
        tick(); #1;
        check("t6_ready", 64'(req_ready_o), 64'h3);
        check("t6_rsp", 64'(rsp_valid_o), 64'h0);
        tick(); #1;
        check("t6_rsp2", 64'(rsp_valid_o), 64'h0);
        check("t6_busy", 64'(busy_o), 64'h0);

        // randomized traffic against the behavioural model
        for (int w = 0; w < 2; w++) begin
            mh_v[w] = 1'b0; mh_we[w] = 1'b0; mh_addr[w] = '0;
            mh_wdata[w] = '0; mh_wmask[w] = '0; mh_pid[w] = '0; m_rsp_d[w] = '0;
        end
        m_rsp_v = 2'b00; act = -1; mflushed = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            flush_i       = ($urandom_range(0, 19) == 0);
            mem_data_ok_i = ($urandom_range(0, 2) == 0);
            mem_wstate_i  = ($urandom_range(0, 2) == 0) ? 3'b111 : 3'($urandom_range(0, 6));
            mem_rdata_i   = {$urandom, $urandom};
            for (int w = 0; w < 2; w++) begin
                req_valid_i[w] = ($urandom_range(0, 1) == 1);
                set_req(w, 1'($urandom_range(0, 1)),
                        ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom | 32'h4),
                        {$urandom, $urandom}, 4'($urandom), 2'($urandom));
                req_valid_i[w] = ($urandom_range(0, 1) == 1);
            end
            #1;
            e_ready = {~mh_v[1] & ~flush_i, ~mh_v[0] & ~flush_i};
            e_raddr = '0; e_waddr = '0; e_wdata = '0; e_wmask = '0;
            if (act >= 0) begin
                if (mh_we[act]) begin
                    e_waddr = mh_addr[act]; e_wdata = mh_wdata[act]; e_wmask = mh_wmask[act];
                end else begin
                    e_raddr = mh_addr[act];
                end
            end
            check("rnd_ready", 64'(req_ready_o), 64'(e_ready));
            check("rnd_raddr", 64'(mem_raddr_o), 64'(e_raddr));
            check("rnd_waddr", 64'(mem_waddr_o), 64'(e_waddr));
            check("rnd_wdata", mem_wdata_o, e_wdata);
            check("rnd_wmask", 64'(mem_wmask_o), 64'(e_wmask));
            check("rnd_busy", 64'(busy_o), (act >= 0) ? 64'h1 : 64'h0);
            check("rnd_rsp_valid", 64'(rsp_valid_o), 64'(m_rsp_v));
            check("rnd_rdata0", rsp_rdata_o[63:0], m_rsp_d[0]);
            check("rnd_rdata1", rsp_rdata_o[127:64], m_rsp_d[1]);

            nxt_rsp  = 2'b00;
            done     = (act >= 0) && (mh_we[act] ? (mem_wstate_i == 3'b111) : mem_data_ok_i);
            nact     = act;
            if (act >= 0) begin
                if (done) begin
                    if (!flush_i && !mflushed) begin
                        nxt_rsp[act] = 1'b1;
                        m_rsp_d[act] = mh_we[act] ? 64'h0 : mem_rdata_i;
                    end
                    nact     = (mh_v[1-act] && !flush_i) ? 1 - act : -1;
                    mflushed = 1'b0;
                end else begin
                    mflushed = mflushed | flush_i;
                end
            end else begin
                mflushed = 1'b0;
                if (!flush_i && (mh_v[0] || mh_v[1]))
                    nact = (mh_v[0] && mh_v[1]) ? model_pick(mh_pid[0], mh_pid[1]) : (mh_v[0] ? 0 : 1);
            end
            for (int w = 0; w < 2; w++) begin
                if ((act == w) && done) mh_v[w] = 1'b0;
                if (flush_i && (act != w)) mh_v[w] = 1'b0;
                if (req_valid_i[w] && e_ready[w]) begin
                    if (req_addr_i[w*ADDR_W +: ADDR_W] == 32'h0) begin
                        nxt_rsp[w] = 1'b1;
                        m_rsp_d[w] = 64'h0;
                    end else begin
                        mh_v[w]     = 1'b1;
                        mh_we[w]    = req_we_i[w];
                        mh_addr[w]  = req_addr_i[w*ADDR_W +: ADDR_W];
                        mh_wdata[w] = req_wdata_i[w*DATA_W +: DATA_W];
                        mh_wmask[w] = req_wmask_i[w*MASK_W +: MASK_W];
                        mh_pid[w]   = req_pid_i[w*2 +: 2];
                    end
                end
            end
            m_rsp_v = nxt_rsp;
            act     = nact;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data-RAM port between the way0 and way1 memory-access stages of the dual-issue core.
- Each way owns a one-entry holding register. The arbiter grants one held request at a time, drives the RAM read/write address bus, and waits for completion (dataOk for reads, writeState all-ones for writes).
- On completion it returns a one-cycle response to the owning way.
- Older instruction (by 2-bit pID, wrap-around compare) wins on conflict. The next pending request chains to the bus with no idle bubble.

Parameters:
- ADDR_W, 32, RAM address width.
- DATA_W, 64, RAM data width.
- MASK_W, 4, write mask width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset; asynchronous, active-low.
- flush_i  in  1  pipeline flush; drops queued requests and suppresses the in-flight response.
- req_valid_i  in  2  per-way request valid (index = way).
- req_ready_o  out  2  per-way request ready; equals the holding register being empty.
- req_we_i  in  2  1 = write, 0 = read.
- req_addr_i  in  2xADDR_W  request address.
- req_wdata_i  in  2xDATA_W  write data.
- req_wmask_i  in  2xMASK_W  write mask.
- req_pid_i  in  2x2  program-order ID.
- rsp_valid_o  out  2  one-cycle completion pulse.
- rsp_rdata_o  out  2xDATA_W  read data; 0 for writes.
- mem_raddr_o  out  ADDR_W  RAM read address; nonzero = read active.
- mem_waddr_o  out  ADDR_W  RAM write address; nonzero = write active.
- mem_wdata_o  out  DATA_W  RAM write data.
- mem_wmask_o  out  MASK_W  RAM write mask.
- mem_rdata_i  in  DATA_W  RAM read data, valid with mem_data_ok_i.
- mem_data_ok_i  in  1  read complete.
- mem_wstate_i  in  3  RAM write state; 3'b111 = write complete.
- busy_o  out  1  FSM not in IDLE.

Behaviour:
- Reset values: FSM IDLE, both holds empty, rsp_valid_o = 0, rsp_rdata_o = 0, all mem_* outputs = 0, req_ready_o = 2'b11, busy_o = 0. Reset is asynchronous, so the bus clears immediately, including mid-transaction.
- Acceptance:
  - A request is accepted in cycle C when req_valid_i[w] & req_ready_o[w]; the hold is loaded at the end of C.
  - req_ready_o[w] = ~hold_valid[w] & ~flush_i.
- Address-0 requests: never enter the hold. They produce rsp_valid_o[w] = 1 with rdata 0 in C+1 and cause no bus activity (address 0 encodes an idle bus).
- FSM states:
  - IDLE: if any hold is valid and not granted, grant the winner. Go to READ or WRITE per its we bit at end of cycle, so the bus is driven from C+2 onward.
  - READ: mem_raddr_o = granted addr. On mem_data_ok_i in cycle D:
    - latch mem_rdata_i;
    - rsp_valid_o[g] = 1 in D+1;
    - clear hold g at end of D.
  - WRITE: mem_waddr_o, mem_wdata_o and mem_wmask_o come from the granted hold. Completion when mem_wstate_i == 3'b111; otherwise stay (e.g. 3'b110 holds state).
  - On completion: if the other hold is valid, grant it and go directly to its state, so its address is on the bus in D+1 with no IDLE cycle. Otherwise go to IDLE.
- Bus outputs are a combinational function of state and granted hold. Every unused mem_* output is 0.
- Priority when both holds are eligible:
  - a is older than b iff (pid_b − pid_a) mod 4 ∈ {1,2};
  - equal pIDs: way0 wins.
  - The just-completed way cannot re-request in D because its ready is low, so no starvation.
- Flush in cycle F:
  - every non-granted hold is cleared at end of F;
  - an in-flight bus transaction runs to RAM completion, but its rsp_valid_o is suppressed;
  - address-0 responses pending for C+1 = F+1 are also suppressed;
  - FSM returns to IDLE after completion;
  - req_ready_o = 0 during F.
- Simultaneous flush and completion in the same cycle: response suppressed, hold cleared, next state IDLE.
- rsp_rdata_o holds its last value when rsp_valid_o = 0.

Decomposition:
- Package mem_arb_pkg holds:
  - arb_state_e {IDLE, READ, WRITE};
  - localparam WSTATE_DONE = 3'b111;
  - struct mem_req_t {we, addr, wdata, wmask, pid};
  - function is_older(pid_a, pid_b).
- Sub-module mem_arb_hold_entry: the one-entry holding register with load, clear, flush and valid. Instantiated twice, one per way.

Test Plan:
- way0 read 0x8000_0100, mem_data_ok_i 3 cycles after the bus is driven with rdata 0xDEAD_BEEF_CAFE_F00D -> mem_raddr_o nonzero from C+2 until D; rsp_valid_o[0] high exactly in D+1 with matching data; req_ready_o[0] low C+1..D.
- Same-cycle requests: way0 write pID 3 at 0x8000_0040, way1 read pID 0 -> way0 serviced first (wrap compare); way1 address on the bus the cycle after write completion, no IDLE cycle.
- Write with mem_wstate_i held at 3'b110 for 5 cycles, then 3'b111 -> stays WRITE with mem_waddr_o stable; rsp_valid_o pulses once; mem_waddr_o returns to 0.
- way1 request addr 0 -> rsp_valid_o[1] = 1 with rdata 0 next cycle; all mem_* outputs stay 0; busy_o stays 0.
- flush_i during in-flight way0 read with way1 held -> way1 hold dropped; read completes on the bus with no rsp_valid_o; FSM IDLE; both ready = 1 afterwards.
- reset_n asserted mid-WRITE -> mem_waddr_o, mem_wdata_o and busy_o go to 0 immediately; after release req_ready_o = 2'b11 and no spurious rsp_valid_o.
